// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Build option UART_TX_FIFO_EN (used by uart_tx_fifo) selects a FIFO buffer
// instead of a single holding register.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [31:0] UART_OFS_DATA   = 32'd0;
    localparam logic [31:0] UART_OFS_STATUS = 32'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer with a combinational head output.
// UART_TX_FIFO_EN defined  : 2^DEPTH_LOG2-entry FIFO. The pointers carry one
//                            extra MSB so full and empty can be told apart.
// UART_TX_FIFO_EN undefined: single holding register, full means occupied.
// The caller only asserts push when the byte is accepted and only asserts pop
// when the buffer is non-empty.
module uart_tx_fifo
`ifdef UART_TX_FIFO_EN
#(
    parameter int DEPTH_LOG2 = 3
)
`endif
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;

    // Read/write pointers, wrapping modulo the depth with one extra lap bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[DEPTH_LOG2-1:0]] <= din;
    end

    assign dout  = mem[rptr[DEPTH_LOG2-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
`else
    logic [7:0] hold;
    logic       occ;

    // Holding register; a push in the same cycle as a pop refills it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold <= '0;
            occ  <= 1'b0;
        end else if (push) begin
            hold <= din;
            occ  <= 1'b1;
        end else if (pop) begin
            occ  <= 1'b0;
        end
    end

    assign dout  = hold;
    assign full  = occ;
    assign empty = ~occ;
`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// DATA at BASE_ADDR (store pushes wdata[7:0]), STATUS at BASE_ADDR+4
// (bit0 full, bit1 empty, bit2 sticky overflow; store with wdata[2] clears).
// Build option UART_TX_FIFO_EN selects a FIFO buffer (see uart_tx_fifo).
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); pops the next byte at its end if one is waiting
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int          CLK_DIV         = 16,
    parameter int          FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid,
    input  logic        write,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    uart_state_e state, state_nx;
    logic [15:0] divcnt, divcnt_nx;
    logic [2:0]  bitcnt, bitcnt_nx;
    logic [7:0]  shift, shift_nx;
    logic        pop;
    logic        ovf;

    logic        hit_data, hit_status;
    logic        push_req, push_ok, ovf_set, ovf_clr;
    logic        buf_full, buf_empty;
    logic [7:0]  buf_dout;
    logic [31:0] status;
    logic        unused_bits;

    assign hit_data   = valid && (addr == BASE_ADDR + UART_OFS_DATA);
    assign hit_status = valid && (addr == BASE_ADDR + UART_OFS_STATUS);

    // A push into a full buffer survives only if the head leaves on the same edge.
    assign push_req = hit_data & write & wmask[0];
    assign push_ok  = push_req & (~buf_full | pop);
    assign ovf_set  = push_req & buf_full & ~pop;
    assign ovf_clr  = hit_status & write & wmask[0] & wdata[2];

    assign unused_bits = ^{wmask[3:1], wdata[31:8]};

    uart_tx_fifo
`ifdef UART_TX_FIFO_EN
    #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    )
`endif
    u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_ok),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Status word as seen after the previous edge.
    always_comb begin
        status           = '0;
        status[ST_FULL]  = buf_full;
        status[ST_EMPTY] = buf_empty && (state == IDLE);
        status[ST_OVF]   = ovf;
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            divcnt <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            state  <= state_nx;
            divcnt <= divcnt_nx;
            bitcnt <= bitcnt_nx;
            shift  <= shift_nx;
        end
    end

    // Next-state logic; divcnt is a down-counter with terminal count at zero.
    always_comb begin
        state_nx  = state;
        divcnt_nx = divcnt;
        bitcnt_nx = bitcnt;
        shift_nx  = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!buf_empty) begin
                    pop       = 1'b1;
                    shift_nx  = buf_dout;
                    divcnt_nx = DIV_LAST;
                    state_nx  = START;
                end
            end
            START: begin
                if (divcnt == 16'd0) begin
                    divcnt_nx = DIV_LAST;
                    bitcnt_nx = 3'd0;
                    state_nx  = DATA;
                end else begin
                    divcnt_nx = divcnt - 16'd1;
                end
            end
            DATA: begin
                if (divcnt == 16'd0) begin
                    divcnt_nx = DIV_LAST;
                    shift_nx  = {1'b0, shift[7:1]};
                    bitcnt_nx = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nx = STOP;
                end else begin
                    divcnt_nx = divcnt - 16'd1;
                end
            end
            STOP: begin
                if (divcnt == 16'd0) begin
                    if (!buf_empty) begin
                        pop       = 1'b1;
                        shift_nx  = buf_dout;
                        divcnt_nx = DIV_LAST;
                        state_nx  = START;
                    end else begin
                        state_nx  = IDLE;
                    end
                end else begin
                    divcnt_nx = divcnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered line and busy outputs, one cycle behind the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            busy <= ~buf_empty | (state != IDLE);
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    // Read data updates on any read and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                rdata <= '0;
        else if (valid && !write) rdata <= hit_status ? status : 32'd0;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH_LOG2=3).
// The reference model works on whole frames: each accepted byte gets a pop
// edge of max(push+1, previous pop + 10*DIV), and the line, busy and status
// are derived from that schedule.
module tb_uart_tx_mmio;

    localparam int DIV = 4;
    localparam int FLEN = 10 * DIV;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  wmask = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         push_e;
        int         pop_e;
        logic [7:0] data;
    } frame_t;

    frame_t fr[$];
    int     last_pop = -1000;
    bit     m_ovf = 1'b0;

    uart_tx_mmio #(
        .BASE_ADDR       (BASE),
        .CLK_DIV         (DIV),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .valid (valid),
        .write (write),
        .wmask (wmask),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bytes still in the buffer just before edge e.
    function automatic int occ_pre(int e);
        int n = 0;
        foreach (fr[i]) if (fr[i].push_e <= e - 1 && fr[i].pop_e >= e) n++;
        return n;
    endfunction

    function automatic bit pop_at(int e);
        foreach (fr[i]) if (fr[i].pop_e == e) return 1'b1;
        return 1'b0;
    endfunction

    // A frame occupies the transmitter for FLEN edges starting at its pop.
    function automatic bit active_pre(int e);
        foreach (fr[i]) if (fr[i].pop_e <= e - 1 && e - 1 < fr[i].pop_e + FLEN) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_tx(int t);
        foreach (fr[i]) begin
            int s;
            s = t - (fr[i].pop_e + 1);
            if (s >= 0 && s < FLEN) begin
                int j;
                j = s / DIV;
                if (j == 0) return 1'b0;
                if (j == 9) return 1'b1;
                return fr[i].data[j-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int t);
        return (occ_pre(t) > 0) || active_pre(t);
    endfunction

    function automatic logic [31:0] exp_status(int e);
        logic [31:0] s;
        s    = 32'h0;
        s[0] = (occ_pre(e) == DEPTH);
        s[1] = (occ_pre(e) == 0) && !active_pre(e);
        s[2] = m_ovf;
        return s;
    endfunction

    function automatic void model_store(int e, logic [31:0] a, logic [3:0] m, logic [31:0] d);
        frame_t f;
        int p;
        if (a == BASE && m[0]) begin
            if (occ_pre(e) < DEPTH || pop_at(e)) begin
                p = (e + 1 > last_pop + FLEN) ? e + 1 : last_pop + FLEN;
                f.push_e = e;
                f.pop_e  = p;
                f.data   = d[7:0];
                fr.push_back(f);
                last_pop = p;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (a == STAT && m[0] && d[2]) begin
            m_ovf = 1'b0;
        end
    endfunction

    // Continuous line/busy checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            assert (tx === exp_tx(cyc)) else begin
                n_err++;
                $error("FAIL tx t=%0d observed %b expected %b", cyc, tx, exp_tx(cyc));
            end
            n_vec++;
            assert (busy === exp_busy(cyc)) else begin
                n_err++;
                $error("FAIL busy t=%0d observed %b expected %b", cyc, busy, exp_busy(cyc));
            end
        end
    end

    // Drive one bus request at the current negedge; it is sampled at edge cyc+1.
    task automatic bus_op(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        int e;
        e     = cyc + 1;
        valid = 1'b1;
        write = w;
        addr  = a;
        wmask = m;
        wdata = d;
        if (w) model_store(e, a, m, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        write = 1'b0;
        wmask = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_check(input logic [31:0] a, input string tag, output logic [31:0] expv);
        expv = (a == STAT) ? exp_status(cyc + 1) : 32'h0;
        bus_op(1'b0, a, 4'h0, $urandom);
        valid = 1'b0;
        n_vec++;
        assert (rdata === expv) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, rdata, expv);
        end
    endtask

    task automatic drain();
        int n;
        n = last_pop + FLEN + 4 - cyc;
        if (n < 2) n = 2;
        if (n > 5000) n = 5000;
        idle(n);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        int sel;
        int gap;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        n_vec++;
        assert (tx === 1'b1) else begin n_err++; $error("FAIL reset_tx observed %b expected 1", tx); end
        n_vec++;
        assert (busy === 1'b0) else begin n_err++; $error("FAIL reset_busy observed %b expected 0", busy); end
        n_vec++;
        assert (rdata === 32'h0) else begin n_err++; $error("FAIL reset_rdata observed %h expected 0", rdata); end
        rstn   = 1'b1;
        mon_en = 1'b1;
        idle(4);
        rd_check(STAT, "status_after_reset", v);
        rd_check(BASE, "read_data_reg", v);

        // Single 0x55 frame.
        bus_op(1'b1, BASE, 4'hF, 32'hABCD_EF55);
        idle(10);
        rd_check(STAT, "status_mid_frame", v);
        drain();
        rd_check(STAT, "status_after_single", v);

        // Nine back-to-back stores.
        for (int i = 0; i < 9; i++) bus_op(1'b1, BASE, 4'h1, $urandom);
        idle(1);
        rd_check(STAT, "status_after_nine", v);
        drain();
        bus_op(1'b1, STAT, 4'h1, 32'h4);
        idle(1);

        // Ten stores: the last one overflows a depth-8 FIFO.
        for (int i = 0; i < 10; i++) bus_op(1'b1, BASE, 4'hF, $urandom);
        idle(1);
        rd_check(STAT, "status_after_ten", v);
        bus_op(1'b1, STAT, 4'hF, 32'h4);
        rd_check(STAT, "status_after_clear", v);
        drain();

        // Ignored stores: wrong lane and unmapped address; rdata must hold.
        rd_check(STAT, "status_before_ignored", held);
        bus_op(1'b1, BASE, 4'b0010, 32'h0000_00A5);
        bus_op(1'b1, BASE + 32'h8, 4'hF, 32'h0000_00A5);
        idle(6);
        n_vec++;
        assert (rdata === held) else begin n_err++; $error("FAIL rdata_hold observed %h expected %h", rdata, held); end
        rd_check(STAT, "status_after_ignored", v);
        rd_check(BASE + 32'h8, "read_unmapped", v);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      bus_op(1'b1, BASE, 4'($urandom) | 4'h1, $urandom);
            else if (sel == 6) bus_op(1'b1, BASE, 4'($urandom) & 4'hE, $urandom);
            else if (sel == 7) bus_op(1'b1, BASE + 32'(4 * $urandom_range(2, 5)), 4'hF, $urandom);
            else if (sel == 8) rd_check(STAT, "status_random", v);
            else               bus_op(1'b1, STAT, 4'h1, $urandom);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : 0;
            if (gap > 0) idle(gap);
        end
        valid = 1'b0;
        drain();
        rd_check(STAT, "status_after_random", v);

        // Reset in the middle of the data bits.
        bus_op(1'b1, BASE, 4'h1, 32'h0000_0000);
        idle(14);
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        fr.delete();
        last_pop = -1000;
        m_ovf    = 1'b0;
        #1;
        n_vec++;
        assert (tx === 1'b1) else begin n_err++; $error("FAIL reset_mid_tx observed %b expected 1", tx); end
        n_vec++;
        assert (busy === 1'b0) else begin n_err++; $error("FAIL reset_mid_busy observed %b expected 0", busy); end
        @(negedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;
        idle(2);
        rd_check(STAT, "status_after_mid_reset", v);
        idle(50);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
